// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction-memory loader:
//   - state_e            : loader FSM states (ST_CHECK only with LOADER_CHECKSUM_EN)
//   - END_WORD_DEFAULT   : end-of-program marker word
//   - BYTES_PER_WORD     : bytes assembled into one instruction word
//   - word_xor()         : XOR of the four bytes of a word (checksum helper)
// Optional feature macro: LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
package loader_pkg;

    localparam logic [31:0] END_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_e;

    // Byte-wise XOR of one instruction word, folded into the running checksum.
    function automatic logic [7:0] word_xor(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Receives a byte stream after a start pulse, assembles bytes big-endian into
// 32-bit words and writes them to consecutive instruction-memory words from
// address 0. Loading ends on END_WORD (never written) or when DEPTH words have
// been written. busy holds the CPU while a load is in progress.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : one-cycle pulse, honoured in IDLE or DONE only
//   in_data/in_valid    : incoming byte stream
//   in_ready            : loader accepts a byte this cycle
//   mem_we/mem_addr/mem_wdata : instruction-memory write port
//   busy, done, full    : load status
//   word_count          : words written in the current load
//   cksum_err           : checksum mismatch (0 unless LOADER_CHECKSUM_EN)
//
// Optional feature macro: LOADER_CHECKSUM_EN -- after END_WORD one extra byte
// is accepted and compared against the running XOR of all written bytes.
//
// All outputs are flops; their next values are derived from the next state so
// they line up with the state they describe.
// -----------------------------------------------------------------------------
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int          DEPTH    = 32,
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] END_WORD = END_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   word_count,
    output logic              cksum_err
);

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] COUNT_ZERO = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0] COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [1:0]      LAST_BYTE  = 2'(BYTES_PER_WORD - 1);

    state_e            state_q,      state_d;
    logic [1:0]        byte_cnt_q,   byte_cnt_d;
    logic [31:0]       word_q,       word_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              full_q,       full_d;
    logic              in_ready_q,   in_ready_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [31:0]       mem_wdata_q,  mem_wdata_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              hs_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xor_q,        xor_d;
    logic              cksum_err_q,  cksum_err_d;
`endif

    // in_ready_q mirrors the current state, so this is the real transfer.
    assign hs_s = in_valid & in_ready_q;

    // Next-state and next-output computation for the loader FSM.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        word_count_d = word_count_q;
        full_d       = full_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d        = xor_q;
        cksum_err_d  = cksum_err_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_RECV;
                    byte_cnt_d   = 2'd0;
                    word_count_d = COUNT_ZERO;
                    full_d       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    xor_d        = 8'h00;
                    cksum_err_d  = 1'b0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_RECV: begin
                if (hs_s) begin
                    word_d = {word_q[23:0], in_data};
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = 2'd0;
                        state_d    = ST_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else begin
                    word_d = word_q;
                end
            end
            ST_WRITE: begin
                if (word_q == END_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    word_count_d = word_count_q + COUNT_ONE;
`ifdef LOADER_CHECKSUM_EN
                    xor_d        = xor_q ^ word_xor(word_q);
`endif
                    // A load that fills memory never sees a checksum byte.
                    if (word_count_d == COUNT_FULL) begin
                        full_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RECV;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (hs_s) begin
                    cksum_err_d = (in_data != xor_q);
                    state_d     = ST_DONE;
                end else begin
                    state_d = state_q;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs describe the state being entered, so they are flop-aligned.
`ifdef LOADER_CHECKSUM_EN
        in_ready_d = (state_d == ST_RECV) || (state_d == ST_CHECK);
        busy_d     = (state_d == ST_RECV) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
`else
        in_ready_d = (state_d == ST_RECV);
        busy_d     = (state_d == ST_RECV) || (state_d == ST_WRITE);
`endif
        done_d      = (state_d == ST_DONE);
        mem_we_d    = (state_d == ST_WRITE) && (word_d != END_WORD);
        mem_addr_d  = word_count_d[ADDR_W-1:0];
        mem_wdata_d = word_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= 2'd0;
            word_q       <= 32'h0000_0000;
            word_count_q <= COUNT_ZERO;
            full_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= 32'h0000_0000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= 8'h00;
            cksum_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            word_count_q <= word_count_d;
            full_q       <= full_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= xor_d;
            cksum_err_q  <= cksum_err_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign full       = full_q;
    assign word_count = word_count_q;
`ifdef LOADER_CHECKSUM_EN
    assign cksum_err  = cksum_err_q;
`else
    assign cksum_err  = 1'b0;
`endif

endmodule
